ifetch_ahb_master: RTL and testbench
====================================

// Module: ifetch_ahb_master
// PURPOSE
//  Instruction-fetch bus initiator. Issues 64-bit read-only AHB-style transfers to the instruction ROM.
//  Splits each returned beat into two 32-bit instructions and buffers them in a FIFO.
//  Presents the instructions, each with its PC, to decode over a valid/ready handshake.
//  Sits between the core front end and the instruction-memory slave.
// PARAMETERS
//  RESET_PC    64'h0  fetch PC after reset; bits [1:0] are ignored
//  FIFO_DEPTH  4      instruction FIFO entries; power of 2, >= 2
// PORTS
//  HCLK            in   1   clock; all state updates on the rising edge
//  HRESET          in   1   synchronous, active-high reset
//  HADDR           out  64  fetch address, always 8-byte aligned
//  HTRANS          out  2   2'b10 NONSEQ in the address phase, otherwise 2'b00 IDLE
//  HWRITE          out  1   tied 0
//  HSIZE           out  3   tied 3'b011 (64-bit)
//  HWDATA          out  64  tied 0
//  HRDATA          in   64  read data; byte at HADDR is in bits [7:0] (little-endian)
//  HREADY          in   1   1 = current phase completes this cycle
//  redirect_valid  in   1   pulse: flush and refetch from redirect_pc
//  redirect_pc     in   64  new PC; bits [1:0] are ignored
//  inst_valid      out  1   FIFO head holds a valid instruction
//  inst            out  32  instruction at the FIFO head
//  inst_pc         out  64  byte address of inst
//  inst_ready      in   1   decode accepts the head this cycle
// BEHAVIOUR
//  Reset:
//   - state=IDLE, fpc=RESET_PC & ~3, FIFO empty, discard=0.
//   - HTRANS=00, HADDR=fpc & ~7, inst_valid=0, inst=0, inst_pc=0.
//  FSM (non-pipelined: no new address phase during a data phase):
//   - IDLE -> ADDR when free slots >= 2. Free slots = FIFO_DEPTH - count, counting pops this cycle.
//   - ADDR: HTRANS=NONSEQ, HADDR=fpc&~7. Held stable while HREADY=0. Goes to DATA on HREADY=1.
//   - DATA: HTRANS=IDLE. Waits for HREADY=1, then samples HRDATA.
//     Next state is ADDR if free slots >= 2 after the write, else IDLE.
//  Beat unpack (when HREADY=1 in DATA and discard=0):
//   - fpc[2]=0: push HRDATA[31:0] @fpc, then HRDATA[63:32] @fpc+4; fpc += 8.
//   - fpc[2]=1: push HRDATA[63:32] @fpc only; fpc += 4.
//   - Address arithmetic is modulo 2^64 (wraps silently).
//  FIFO:
//   - Up to 2 writes and 1 read per cycle. Pop when inst_valid & inst_ready.
//   - Head is visible the cycle after it is written; no fall-through.
//   - The FIFO never overflows; the free-slot gate guarantees it.
//   - inst/inst_pc are held when inst_valid=0.
//  Latency: with zero wait states the first NONSEQ is on cycle 1 after reset release.
//   inst_valid rises on cycle 3. Sustained rate: 2 instructions per 2 cycles.
//  Redirect (highest priority):
//   - Same edge: FIFO flushed, fpc <= redirect_pc & ~3. Any same-cycle pop is ignored.
//   - inst_valid=0 the next cycle.
//   - ADDR phase with HREADY=0: address held (AHB rule), discard set, transfer completes normally.
//   - ADDR phase with HREADY=1: discard set.
//   - DATA phase: discard set.
//   - A beat completing with discard=1 is dropped and discard clears.
//     fpc is unchanged by that beat; the next address phase uses the redirected fpc.
//   - In IDLE: takes effect immediately, no discard.
//   - A second redirect before the discard completes overwrites fpc; discard stays 1.
//  Reset mid-transfer: abandons the transfer; HTRANS=IDLE on the next cycle.
//  HRESP is not used; error responses are out of scope.
// TESTING
//  1. Reset release, HREADY=1, HRDATA@0=64'h0080_0113_0400_0093
//     -> HADDR=0 NONSEQ on cycle 1; inst=32'h0400_0093 pc=0 on cycle 3;
//        then 32'h0080_0113 pc=4.
//  2. inst_ready=0 with FIFO_DEPTH=4 -> exactly 2 beats fetched (addr 0, 8);
//     HTRANS stays IDLE until one pop frees 2 slots... i.e. after 2 pops.
//  3. HREADY=0 for 3 cycles in the ADDR phase -> HADDR and NONSEQ held stable;
//     data accepted only after the DATA phase sees HREADY=1.
//  4. redirect_valid with redirect_pc=64'h14 during a DATA phase -> that beat is discarded;
//     next HADDR=64'h10; only inst @0x14 is pushed; next HADDR=64'h18.
//  5. Redirect and inst_ready in the same cycle -> no pop counted; FIFO empty next cycle.
//  6. HRESET asserted mid-DATA -> next cycle HTRANS=00, inst_valid=0;
//     refetch starts from RESET_PC.
```

Note on scenario 2: with FIFO_DEPTH=4 and 4 entries full, one pop leaves only 1 free slot. A second pop is needed before the 2-slot gate opens, and then HTRANS=NONSEQ to address 16.

Source files
------------

// File: rtl/ifetch_ahb_master.sv
// Instruction-fetch AHB read initiator: 64-bit beats split into two 32-bit instructions, queued with their PCs.
// Latency: first NONSEQ one cycle after reset release, first instruction valid two cycles later (zero wait states).
// Backpressure: a new address phase starts only when at least two FIFO slots are free; decode stalls via inst_ready.
module ifetch_ahb_master #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        HCLK,
   input  logic        HRESET,
   output logic [63:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [63:0] HWDATA,
   input  logic [63:0] HRDATA,
   input  logic        HREADY,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [63:0] inst_pc,
   input  logic        inst_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   // Highest occupancy that still leaves room for a full two-instruction beat
   localparam logic [CW-1:0] LP_GATE = CW'(FIFO_DEPTH - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [63:0]   r_fpc, w_fpc_nxt;
   logic [63:0]   r_haddr;
   logic          r_discard, w_discard_nxt;

   logic [31:0]   r_mem_inst [FIFO_DEPTH];
   logic [63:0]   r_mem_pc   [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
   logic [CW-1:0] r_count, w_count_left, w_count_nxt;
   logic [31:0]   r_inst;
   logic [63:0]   r_inst_pc;

   logic          w_beat, w_push0, w_push1, w_pop;
   logic [31:0]   w_d0, w_d1;
   logic [63:0]   w_pc0, w_pc1;

   // A redirect squashes any same-cycle pop; the whole queue is discarded anyway
   assign w_pop        = (r_count != '0) && inst_ready && !redirect_valid;
   assign w_beat       = (r_state == S_DATA) && HREADY;
   assign w_push0      = w_beat && !r_discard && !redirect_valid;
   // An odd-word fetch PC means the low half of the beat lies before the PC
   assign w_push1      = w_push0 && !r_fpc[2];
   assign w_d0         = r_fpc[2] ? HRDATA[63:32] : HRDATA[31:0];
   assign w_pc0        = r_fpc;
   assign w_d1         = HRDATA[63:32];
   assign w_pc1        = r_fpc + 64'd4;
   assign w_rptr_nxt   = r_rptr + AW'(w_pop);
   assign w_count_left = r_count - CW'(w_pop);

   // Next state, fetch PC, discard flag and occupancy after this edge
   always_comb begin
      w_state_nxt   = r_state;
      w_fpc_nxt     = r_fpc;
      w_discard_nxt = r_discard;
      w_count_nxt   = w_count_left + CW'(w_push0) + CW'(w_push1);
      if (w_push0) begin
         w_fpc_nxt = r_fpc + (r_fpc[2] ? 64'd4 : 64'd8);
      end
      if (w_beat) begin
         w_discard_nxt = 1'b0;
      end
      if (redirect_valid) begin
         w_fpc_nxt   = redirect_pc & ~64'h3;
         w_count_nxt = '0;
         // A beat still owed by the slave belongs to the old stream
         if ((r_state == S_ADDR) || ((r_state == S_DATA) && !HREADY)) begin
            w_discard_nxt = 1'b1;
         end
      end
      case (r_state)
         S_IDLE:  if (w_count_nxt <= LP_GATE) w_state_nxt = S_ADDR;
         S_ADDR:  if (HREADY) w_state_nxt = S_DATA;
         S_DATA:  if (HREADY) w_state_nxt = (w_count_nxt <= LP_GATE) ? S_ADDR : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state, fetch PC and the address latched for the address phase
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state   <= S_IDLE;
         r_fpc     <= RESET_PC & ~64'h3;
         r_discard <= 1'b0;
         r_haddr   <= RESET_PC & ~64'h7;
      end else begin
         r_state   <= w_state_nxt;
         r_fpc     <= w_fpc_nxt;
         r_discard <= w_discard_nxt;
         if ((w_state_nxt == S_ADDR) && (r_state != S_ADDR)) begin
            r_haddr <= w_fpc_nxt & ~64'h7;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge HCLK) begin
      if (HRESET || redirect_valid) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(w_push0) + AW'(w_push1);
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
      end
   end

   // FIFO storage, up to two writes per cycle
   always_ff @(posedge HCLK) begin
      if (w_push0) begin
         r_mem_inst[r_wptr] <= w_d0;
         r_mem_pc[r_wptr]   <= w_pc0;
      end
      if (w_push1) begin
         r_mem_inst[r_wptr + AW'(1)] <= w_d1;
         r_mem_pc[r_wptr + AW'(1)]   <= w_pc1;
      end
   end

   // Registered head: loads the next head, holds its value while the queue is empty
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_inst    <= '0;
         r_inst_pc <= '0;
      end else if (w_count_nxt != '0) begin
         if (w_count_left == '0) begin
            r_inst    <= w_d0;
            r_inst_pc <= w_pc0;
         end else begin
            r_inst    <= r_mem_inst[w_rptr_nxt];
            r_inst_pc <= r_mem_pc[w_rptr_nxt];
         end
      end
   end

   assign HTRANS     = (r_state == S_ADDR) ? 2'b10 : 2'b00;
   assign HADDR      = (r_state == S_ADDR) ? r_haddr : (r_fpc & ~64'h7);
   assign HWRITE     = 1'b0;
   assign HSIZE      = 3'b011;
   assign HWDATA     = '0;
   assign inst_valid = (r_count != '0);
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_ifetch_ahb_master.sv
// Bench for ifetch_ahb_master: directed cycle tables and sequences, then random traffic
// against an instruction-stream model (sequential PCs from the last redirect, data from a ROM function).
module tb_ifetch_ahb_master;

   logic        HCLK = 1'b0;
   logic        HRESET = 1'b1;
   logic        HREADY = 1'b1;
   logic [63:0] HRDATA = '0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        inst_ready = 1'b0;
   logic [63:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [63:0] HWDATA;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   ifetch_ahb_master #(.RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   always #5 HCLK = ~HCLK;

   int          checks = 0;
   int          errors = 0;
   logic        dphase = 1'b0;
   logic [63:0] daddr = '0;
   logic        p_wait = 1'b0;
   logic        p_rv = 1'b0;
   logic [63:0] p_haddr = '0;

   typedef struct {
      logic        hready;
      logic        rdy;
      logic [1:0]  htrans;
      logic        chk_addr;
      logic [63:0] haddr;
      logic        valid;
      logic [63:0] pc;
      logic [31:0] inst;
   } vec_t;

   vec_t tbl [8];

   // ROM contents: one 32-bit word per 4-byte address
   function automatic logic [31:0] word(input logic [63:0] a);
      if (a == 64'h0) return 32'h0400_0093;
      if (a == 64'h4) return 32'h0080_0113;
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [63:0] beat(input logic [63:0] b);
      return {word(b + 64'd4), word(b)};
   endfunction

   function automatic vec_t mk(input logic [1:0] ht, input logic ca, input logic [63:0] ha,
                               input logic v, input logic [63:0] pc);
      vec_t r;
      r.hready = 1'b1;
      r.rdy = 1'b1;
      r.htrans = ht;
      r.chk_addr = ca;
      r.haddr = ha;
      r.valid = v;
      r.pc = pc;
      r.inst = v ? word(pc) : 32'h0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Runs one cycle: bus rules on the current outputs, drive inputs, slave model, advance one clock
   task automatic tick(input logic hr, input logic rdy, input logic rv, input logic [63:0] rpc,
                       input logic rst);
      logic [31:0] j0, j1;
      if (p_wait) begin
         chk("addr_hold_htrans", 64'(HTRANS), 64'd2);
         chk("addr_hold_haddr", HADDR, p_haddr);
      end
      if (HTRANS == 2'b10) begin
         chk("addr_align", 64'(HADDR[2:0]), 64'd0);
         chk("non_pipelined", 64'(dphase), 64'd0);
      end
      if (p_rv) chk("flush_valid", 64'(inst_valid), 64'd0);
      j0 = $urandom();
      j1 = $urandom();
      HREADY = hr;
      inst_ready = rdy;
      redirect_valid = rv;
      redirect_pc = rpc;
      HRESET = rst;
      HRDATA = (dphase && hr) ? beat(daddr) : {j0, j1};
      p_wait = (HTRANS == 2'b10) && !hr && !rst;
      p_haddr = HADDR;
      p_rv = rv && !rst;
      if (rst) begin
         dphase = 1'b0;
      end else begin
         if (dphase && hr) dphase = 1'b0;
         if ((HTRANS == 2'b10) && hr) begin
            dphase = 1'b1;
            daddr = HADDR;
         end
      end
      @(posedge HCLK);
      @(negedge HCLK);
   endtask

   // Three reset cycles; returns in the first cycle after release (cycle 0)
   task automatic rst_seq();
      for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
   endtask

   initial begin
      logic [63:0] addrs [$];
      logic [63:0] exp_pc, rpc;
      logic [31:0] prev_inst;
      logic [63:0] prev_pc;
      logic        hr, rdy, rv;
      int          delivered;

      tbl[0] = mk(2'b00, 1'b1, 64'h0,  1'b0, 64'h0);
      tbl[1] = mk(2'b10, 1'b1, 64'h0,  1'b0, 64'h0);
      tbl[2] = mk(2'b00, 1'b0, 64'h0,  1'b0, 64'h0);
      tbl[3] = mk(2'b10, 1'b1, 64'h8,  1'b1, 64'h0);
      tbl[4] = mk(2'b00, 1'b0, 64'h0,  1'b1, 64'h4);
      tbl[5] = mk(2'b10, 1'b1, 64'h10, 1'b1, 64'h8);
      tbl[6] = mk(2'b00, 1'b0, 64'h0,  1'b1, 64'hC);
      tbl[7] = mk(2'b10, 1'b1, 64'h18, 1'b1, 64'h10);

      @(negedge HCLK);

      // Reset release and zero-wait-state streaming
      rst_seq();
      chk("tie_hwrite", 64'(HWRITE), 64'd0);
      chk("tie_hsize", 64'(HSIZE), 64'd3);
      chk("tie_hwdata", HWDATA, 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tbl%0d_htrans", i), 64'(HTRANS), 64'(tbl[i].htrans));
         if (tbl[i].chk_addr) chk($sformatf("tbl%0d_haddr", i), HADDR, tbl[i].haddr);
         chk($sformatf("tbl%0d_valid", i), 64'(inst_valid), 64'(tbl[i].valid));
         chk($sformatf("tbl%0d_inst", i), 64'(inst), 64'(tbl[i].inst));
         chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].pc);
         tick(tbl[i].hready, tbl[i].rdy, 1'b0, 64'h0, 1'b0);
      end

      // Decode stalled: two beats fill the FIFO, two pops reopen the gate
      rst_seq();
      for (int c = 0; c < 10; c++) begin
         if (HTRANS == 2'b10) addrs.push_back(HADDR);
         tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      end
      chk("stall_nbeats", 64'(addrs.size()), 64'd2);
      if (addrs.size() >= 2) begin
         chk("stall_addr0", addrs[0], 64'h0);
         chk("stall_addr1", addrs[1], 64'h8);
      end
      chk("stall_idle", 64'(HTRANS), 64'd0);
      chk("stall_head_pc", inst_pc, 64'h0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("one_pop_idle", 64'(HTRANS), 64'd0);
      chk("one_pop_pc", inst_pc, 64'h4);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("two_pop_nonseq", 64'(HTRANS), 64'd2);
      chk("two_pop_haddr", HADDR, 64'h10);
      chk("two_pop_pc", inst_pc, 64'h8);

      // Redirect together with inst_ready during an address phase
      tick(1'b1, 1'b1, 1'b1, 64'h100, 1'b0);
      chk("rd_pop_valid", 64'(inst_valid), 64'd0);
      chk("rd_pop_htrans", 64'(HTRANS), 64'd0);
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      chk("rd_pop_nonseq", 64'(HTRANS), 64'd2);
      chk("rd_pop_haddr", HADDR, 64'h100);
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      chk("rd_pop_first_pc", inst_pc, 64'h100);
      chk("rd_pop_first_inst", 64'(inst), 64'(word(64'h100)));

      // Wait states in the address phase and in the data phase
      rst_seq();
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("ws_nonseq", 64'(HTRANS), 64'd2);
         chk("ws_haddr", HADDR, 64'h0);
         tick(k == 3, 1'b1, 1'b0, 64'h0, 1'b0);
      end
      chk("ws_data_htrans", 64'(HTRANS), 64'd0);
      tick(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("ws_data_valid", 64'(inst_valid), 64'd0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("ws_first_valid", 64'(inst_valid), 64'd1);
      chk("ws_first_inst", 64'(inst), 64'(word(64'h0)));
      chk("ws_first_pc", inst_pc, 64'h0);

      // Redirect to an odd word during a data phase
      rst_seq();
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("rdd_in_data", 64'(HTRANS), 64'd0);
      tick(1'b1, 1'b1, 1'b1, 64'h14, 1'b0);
      chk("rdd_nonseq", 64'(HTRANS), 64'd2);
      chk("rdd_haddr", HADDR, 64'h10);
      chk("rdd_valid0", 64'(inst_valid), 64'd0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("rdd_next_haddr", HADDR, 64'h18);
      chk("rdd_head_pc", inst_pc, 64'h14);
      chk("rdd_head_inst", 64'(inst), 64'(word(64'h14)));
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("rdd_single_push", 64'(inst_valid), 64'd0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("rdd_after_pc", inst_pc, 64'h18);
      chk("rdd_after_inst", 64'(inst), 64'(word(64'h18)));

      // Reset in the middle of a data phase
      rst_seq();
      for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("mid_rst_pre_valid", 64'(inst_valid), 64'd1);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b1);
      chk("mid_rst_htrans", 64'(HTRANS), 64'd0);
      chk("mid_rst_valid", 64'(inst_valid), 64'd0);
      chk("mid_rst_inst", 64'(inst), 64'd0);
      chk("mid_rst_pc", inst_pc, 64'd0);
      tick(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk("mid_rst_refetch", 64'(HTRANS), 64'd2);
      chk("mid_rst_haddr", HADDR, 64'h0);

      // Random wait states, stalls and redirects against the stream model
      rst_seq();
      exp_pc = 64'h0;
      delivered = 0;
      prev_inst = inst;
      prev_pc = inst_pc;
      for (int n = 0; n < 4000; n++) begin
         hr  = ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 9) < 6);
         rv  = ($urandom_range(0, 99) < 3);
         case ($urandom_range(0, 2))
            0:       rpc = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
            1:       rpc = {32'h0, 20'h0, 12'($urandom())};
            default: rpc = {32'($urandom()), 32'($urandom())};
         endcase
         if (!inst_valid) begin
            chk("hold_inst", 64'(inst), 64'(prev_inst));
            chk("hold_pc", inst_pc, prev_pc);
         end
         if (inst_valid && rdy && !rv) begin
            chk("stream_pc", inst_pc, exp_pc);
            chk("stream_inst", 64'(inst), 64'(word(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            delivered++;
         end
         if (rv) exp_pc = rpc & ~64'h3;
         prev_inst = inst;
         prev_pc = inst_pc;
         tick(hr, rdy, rv, rpc, 1'b0);
      end
      chk("liveness", 64'(delivered >= 400), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
